// File: rtl/sysid_pkg.sv
// sysid_pkg: shared widths, register offsets and CONTROL/STATUS bit indices for the system-ID slave
package sysid_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 64;

    localparam logic [ADDR_W-1:0] OFF_ID      = 3'd0;
    localparam logic [ADDR_W-1:0] OFF_TS      = 3'd1;
    localparam logic [ADDR_W-1:0] OFF_UP_LO   = 3'd2;
    localparam logic [ADDR_W-1:0] OFF_UP_HI   = 3'd3;
    localparam logic [ADDR_W-1:0] OFF_SCRATCH = 3'd4;
    localparam logic [ADDR_W-1:0] OFF_CAPS    = 3'd5;
    localparam logic [ADDR_W-1:0] OFF_STATUS  = 3'd6;
    localparam logic [ADDR_W-1:0] OFF_CONTROL = 3'd7;

    localparam int CTL_CLEAR    = 0;
    localparam int CTL_FREEZE   = 1;
    localparam int CTL_WRAP_CLR = 2;

    localparam int ST_WRAP   = 0;
    localparam int ST_FREEZE = 1;
endpackage

// File: rtl/sysid_timer_slave_if.sv
// sysid_timer_slave_if: Avalon-MM slave bus bundle (pipelined reads, no waitrequest)
interface sysid_timer_slave_if;
    logic [sysid_pkg::ADDR_W-1:0]   address;
    logic                           read;
    logic                           write;
    logic [sysid_pkg::DATA_W-1:0]   writedata;
    logic [sysid_pkg::DATA_W/8-1:0] byteenable;
    logic [sysid_pkg::DATA_W-1:0]   readdata;
    logic                           readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: prescaled 64-bit free-running uptime counter with clear, freeze and wrap pulse
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             freeze,
    output logic [CNT_W-1:0] count,
    output logic             wrap_pulse
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    r_pre;
    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    assign w_tick     = !freeze && (r_pre == PW'(PRESCALE - 1));
    // clear suppresses the increment, so it also suppresses the wrap it would cause
    assign wrap_pulse = w_tick && !clear && (&r_count);
    assign count      = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (!freeze) begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/sysid_timer_slave.sv
// sysid_timer_slave: Avalon-MM slave returning ID, timestamp, caps, scratch, status and a coherent
// 64-bit uptime (LO read latches HI into a shadow) through a READ_LATENCY-stage response pipeline.
module sysid_timer_slave
    import sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] ID_VALUE     = 32'h649C_C080,
    parameter logic [DATA_W-1:0] TIMESTAMP    = 32'd1,
    parameter logic [DATA_W-1:0] CAPS_VALUE   = 32'h0000_0001,
    parameter int                READ_LATENCY = 1,
    parameter int                PRESCALE     = 1
) (
    input logic                clock,
    input logic                reset,
    sysid_timer_slave_if.slave s
);
    logic [CNT_W-1:0]  w_count;
    logic              w_wrap_pulse;
    logic              w_wr_ctl;
    logic              w_clear;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rdata;

    logic [DATA_W-1:0]       r_scratch;
    logic [DATA_W-1:0]       r_shadow;
    logic                    r_wrap;
    logic                    r_freeze;
    logic [DATA_W-1:0]       r_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_vld;

    assign w_wr_ctl = s.write && (s.address == OFF_CONTROL);
    assign w_clear  = w_wr_ctl && s.writedata[CTL_CLEAR];

    sysid_uptime_counter #(.PRESCALE(PRESCALE)) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_clear),
        .freeze     (r_freeze),
        .count      (w_count),
        .wrap_pulse (w_wrap_pulse)
    );

    always_comb begin
        w_status            = '0;
        w_status[ST_WRAP]   = r_wrap;
        w_status[ST_FREEZE] = r_freeze;
        case (s.address)
            OFF_ID:      w_rdata = ID_VALUE;
            OFF_TS:      w_rdata = TIMESTAMP;
            OFF_UP_LO:   w_rdata = w_count[DATA_W-1:0];
            OFF_UP_HI:   w_rdata = r_shadow;
            OFF_SCRATCH: w_rdata = r_scratch;
            OFF_CAPS:    w_rdata = CAPS_VALUE;
            OFF_STATUS:  w_rdata = w_status;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scratch <= '0;
            r_shadow  <= '0;
            r_wrap    <= 1'b0;
            r_freeze  <= 1'b0;
        end else begin
            if (s.write && s.address == OFF_SCRATCH)
                for (int b = 0; b < DATA_W / 8; b++)
                    if (s.byteenable[b]) r_scratch[8*b +: 8] <= s.writedata[8*b +: 8];
            if (s.read && s.address == OFF_UP_LO) r_shadow <= w_count[CNT_W-1:DATA_W];
            if (w_wr_ctl) r_freeze <= s.writedata[CTL_FREEZE];
            // a wrap arriving in the same cycle as a clear request must not be lost
            if (w_wrap_pulse) r_wrap <= 1'b1;
            else if (w_wr_ctl && (s.writedata[CTL_CLEAR] || s.writedata[CTL_WRAP_CLR])) r_wrap <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) r_data[k] <= '0;
        end else begin
            r_vld[0]  <= s.read;
            r_data[0] <= s.read ? w_rdata : '0;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_data[k] <= r_data[k-1];
            end
        end
    end

    assign s.readdata      = r_data[READ_LATENCY-1];
    assign s.readdatavalid = r_vld[READ_LATENCY-1];
endmodule
